// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and datapath-select encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} src_b_e;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10} pc_src_e;
  function automatic state_e decode_next(input logic [5:0] op);
    return op == OP_RTYPE ? R_EXEC :
           op == OP_LW || op == OP_SW ? MEM_ADDR :
           op == OP_ADDI ? I_EXEC :
           op == OP_BEQ ? BRANCH :
           op == OP_J ? JUMP : TRAP;
  endfunction
endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory handshake, retire counter and illegal-opcode trap
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [CNT_W-1:0] instr_retired
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic retire;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    trap          = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        state_d   = decode_next(opcode);
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = opcode == OP_LW ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? FETCH : MEM_WRITE;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      TRAP: trap = 1'b1;
      default: state_d = IDLE;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign instr_retired = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized self-checking bench against an instruction-level timing/effect model
module tb_mips_multicycle_ctrl;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, reset4_n, mem_ready;
  logic [5:0] opcode;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [31:0] instr_retired;
  logic [5:0] opcode4 = J;
  logic mem_ready4 = 1'b1;
  logic pw4, pwc4, iord4, mr4, mw4, irw4, m2r4, rd4, rw4, asa4, trap4;
  logic [1:0] asb4, aop4, pcs4;
  logic [3:0] ret4;
  int errors = 0, checks = 0;
  mips_multicycle_ctrl dut (
    .clock(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .trap(trap), .instr_retired(instr_retired)
  );
  mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clock(clk), .reset_n(reset4_n), .opcode(opcode4), .mem_ready(mem_ready4),
    .pc_write(pw4), .pc_write_cond(pwc4), .iord(iord4), .mem_read(mr4),
    .mem_write(mw4), .ir_write(irw4), .mem_to_reg(m2r4), .reg_dst(rd4),
    .reg_write(rw4), .alu_src_a(asa4), .alu_src_b(asb4), .alu_op(aop4),
    .pc_source(pcs4), .trap(trap4), .instr_retired(ret4)
  );
  function automatic logic [15:0] enables();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction
  function automatic int base_cycles(input logic [5:0] op);
    return op == LW ? 5 : (op == BEQ || op == J) ? 3 : 4;
  endfunction
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int cyc = 0, wl = fw, acc = 0, n_ir = 0, n_rw = 0, n_mw = 0, n_pwc = 0, n_jmp = 0, exp_cyc;
    logic [31:0] start = instr_retired;
    bit done = 0;
    bit is_mem = (op == LW || op == SW);
    while (!done && cyc < 64) begin
      opcode = op;
      if (mem_read || mem_write) begin
        if (wl > 0) begin mem_ready = 1'b0; wl--; end else mem_ready = 1'b1;
      end else mem_ready = 1'($urandom);
      #1;
      if (mem_read || mem_write) begin
        checks++;
        if (iord !== 1'(acc > 0)) begin errors++; $display("FAIL iord op=%b: got %b expected %b", op, iord, acc > 0); end
        if (mem_ready) begin acc++; wl = mw; end
      end
      n_ir += int'(ir_write);
      n_rw += int'(reg_write);
      n_mw += int'(mem_write);
      n_pwc += int'(pc_write_cond);
      n_jmp += int'(pc_write && pc_source == 2'b10);
      if (reg_write) begin
        checks++;
        if (mem_read || mem_write) begin errors++; $display("FAIL rw_excl op=%b: mem_read=%b mem_write=%b expected 0", op, mem_read, mem_write); end
        checks++;
        if (reg_dst !== (op == R) || mem_to_reg !== (op == LW)) begin
          errors++; $display("FAIL wb_sel op=%b: got reg_dst=%b mem_to_reg=%b expected %b %b", op, reg_dst, mem_to_reg, op == R, op == LW);
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (instr_retired !== start) done = 1;
      @(negedge clk);
    end
    exp_cyc = base_cycles(op) + fw + (is_mem ? mw : 0);
    checks++;
    if (cyc != exp_cyc) begin errors++; $display("FAIL latency op=%b: got %0d expected %0d", op, cyc, exp_cyc); end
    checks++;
    if (instr_retired !== start + 1) begin errors++; $display("FAIL retired op=%b: got %0d expected %0d", op, instr_retired, start + 1); end
    checks++;
    if (n_ir != 1) begin errors++; $display("FAIL ir_write op=%b: got %0d pulses expected 1", op, n_ir); end
    checks++;
    if (n_rw != int'(op == R || op == LW || op == ADDI)) begin errors++; $display("FAIL reg_write op=%b: got %0d cycles expected %0d", op, n_rw, op == R || op == LW || op == ADDI); end
    checks++;
    if (n_mw != (op == SW ? mw + 1 : 0)) begin errors++; $display("FAIL mem_write op=%b: got %0d cycles expected %0d", op, n_mw, op == SW ? mw + 1 : 0); end
    checks++;
    if (n_pwc != int'(op == BEQ)) begin errors++; $display("FAIL pc_write_cond op=%b: got %0d expected %0d", op, n_pwc, op == BEQ); end
    checks++;
    if (n_jmp != int'(op == J)) begin errors++; $display("FAIL jump op=%b: got %0d expected %0d", op, n_jmp, op == J); end
  endtask
  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (enables() !== 16'h0 || trap !== 1'b0) begin errors++; $display("FAIL reset_outs: got %h trap=%b expected 0", enables(), trap); end
    checks++;
    if (instr_retired !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", instr_retired); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (enables() !== 16'h0) begin errors++; $display("FAIL idle_outs: got %h expected 0", enables()); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (!(mem_read === 1'b1 && iord === 1'b0 && alu_src_b === 2'b01 && ir_write === 1'b0 && pc_write === 1'b0)) begin
      errors++; $display("FAIL fetch_outs: got %h expected mem_read=1 iord=0 src_b=01 ir_write=0", enables());
    end
  endtask
  task automatic test_r_type();
    run_instr(R, 0, 0);
    checks++;
    if (instr_retired !== 32'd1) begin errors++; $display("FAIL r_count: got %0d expected 1", instr_retired); end
  endtask
  task automatic test_lw_waits();
    run_instr(LW, 2, 3);
  endtask
  task automatic test_sw_beq_j();
    logic [31:0] s = instr_retired;
    run_instr(SW, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(J, 0, 0);
    checks++;
    if (instr_retired !== s + 3) begin errors++; $display("FAIL seq_count: got %0d expected %0d", instr_retired, s + 3); end
  endtask
  task automatic test_random();
    logic [5:0] ops [6] = '{R, LW, SW, ADDI, BEQ, J};
    for (int i = 0; i < 30; i++) run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
  endtask
  task automatic test_trap();
    logic [31:0] s = instr_retired;
    opcode = 6'b111111; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom); mem_ready = 1'($urandom);
      #1;
      checks++;
      if (trap !== 1'b1 || enables() !== 16'h0 || instr_retired !== s) begin
        errors++; $display("FAIL trap_hold cycle %0d: got trap=%b outs=%h cnt=%0d expected 1 0 %0d", i, trap, enables(), instr_retired, s);
      end
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || enables() !== 16'h0) begin errors++; $display("FAIL trap_reset: got trap=%b outs=%h expected 0", trap, enables()); end
  endtask
  task automatic test_async_reset();
    bit hit = 0;
    @(negedge clk);
    reset_n = 1'b1; opcode = LW; mem_ready = 1'b1;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (mem_read && iord) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reach_mem_read: got no MEM_READ expected within 10 cycles"); end
    mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || enables() !== 16'h0) begin errors++; $display("FAIL async_drop: got mem_read=%b outs=%h expected 0", mem_read, enables()); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (enables() !== 16'h0) begin errors++; $display("FAIL async_idle: got %h expected 0", enables()); end
    @(negedge clk);
    #1;
    checks++;
    if (mem_read !== 1'b1 || iord !== 1'b0) begin errors++; $display("FAIL async_fetch: got mem_read=%b iord=%b expected 1 0", mem_read, iord); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (reg_write !== 1'b0) begin errors++; $display("FAIL async_rw cycle %0d: got %b expected 0", i, reg_write); end
      @(negedge clk);
      #1;
    end
  endtask
  task automatic test_wrap();
    logic [3:0] prev;
    int wait_n;
    reset4_n = 1'b0;
    @(negedge clk);
    reset4_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      prev = ret4;
      wait_n = 0;
      while (ret4 === prev && wait_n < 10) begin
        @(negedge clk);
        wait_n++;
      end
      checks++;
      if (ret4 !== 4'(k % 16)) begin errors++; $display("FAIL wrap retire %0d: got %0d expected %0d", k, ret4, k % 16); end
    end
  endtask
  initial begin
    reset4_n = 1'b0;
    test_reset();
    test_r_type();
    test_lw_waits();
    test_sw_beq_j();
    test_random();
    test_trap();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
